// File: rtl/add_bit_pipe_if.sv
// Handshake and data bundle for the add_bit_pipe datapath.
// Upstream drives operands, downstream drives i_ready.
interface add_bit_pipe_if #(
  parameter int M = 8,
  parameter int K = 8
);
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [M-1:0] i_arg_A;
  logic [M-1:0] i_arg_B;
  logic         i_acc_clr;
  logic         o_valid;
  logic         i_ready;
  logic [K-1:0] cache_result;
  logic [3:0]   cache_status;

  modport slave (
    input  i_valid, i_op, i_arg_A, i_arg_B,
    input  i_acc_clr, i_ready,
    output o_ready, o_valid,
    output cache_result, cache_status
  );

  modport master (
    output i_valid, i_op, i_arg_A, i_arg_B,
    output i_acc_clr, i_ready,
    input  o_ready, o_valid,
    input  cache_result, cache_status
  );
endinterface

// File: rtl/add_bit_pipe.sv
// Pipelined add/sub with bit clear/set/toggle and accumulator.
// Two register stages, valid/ready on both sides.
module add_bit_pipe #(
  parameter int M   = 8,
  parameter int K   = 8,
  parameter int SAT = 0
) (
  input logic i_clk,
  input logic i_rst_n,
  add_bit_pipe_if.slave bus
);
  typedef enum logic [1:0] {
    C_OK, C_OVF, C_IDX, C_ILL
  } cls_t;

  localparam logic [M-1:0] ONE    = M'(1);
  localparam logic [M-1:0] MAXIDX = M'(M-1);
  localparam logic [M-1:0] SMAX   = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0] SMIN   = {1'b1, {(M-1){1'b0}}};

  logic [M-1:0] acc;
  logic [M-1:0] opx;
  logic [M-1:0] b;
  logic [M-1:0] mask;
  logic [M-1:0] sum_m;
  logic [M-1:0] bit_res;
  logic [M-1:0] res;
  logic [M-1:0] s1_res;
  logic [M:0]   sum;
  logic [3:0]   status;
  logic         s1_valid;
  logic         s2_load;
  logic         accept;
  logic         ovf;
  logic         in_rng;
  logic         acc_op;
  logic         illegal;
  logic         zero;
  cls_t         cls;
  cls_t         s1_cls;

  assign s2_load     = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = !s1_valid || s2_load;
  assign accept      = bus.i_valid && bus.o_ready;

  always_comb begin
    b       = bus.i_arg_B;
    acc_op  = bus.i_op == 3'b100;
    illegal = bus.i_op > 3'b100;
    opx     = acc_op ? acc : bus.i_arg_A;
    if (bus.i_op == 3'b001)
      sum = {opx[M-1], opx} - {b[M-1], b};
    else
      sum = {opx[M-1], opx} + {b[M-1], b};
    sum_m  = sum[M-1:0];
    ovf    = sum[M] ^ sum[M-1];
    in_rng = !b[M-1] && (b <= MAXIDX);
    mask   = ONE << b;
    unique case (1'b1)
      (bus.i_op == 3'b010): bit_res = sum_m | mask;
      (bus.i_op == 3'b011): bit_res = sum_m ^ mask;
      default:              bit_res = sum_m & ~mask;
    endcase
    // error classes are checked in status priority order
    if (illegal) begin
      cls = C_ILL;
      res = '0;
    end else if (ovf) begin
      cls = C_OVF;
      res = (SAT != 0) ? (sum[M] ? SMIN : SMAX) : '0;
    end else if (!in_rng) begin
      cls = C_IDX;
      res = sum_m;
    end else begin
      cls = C_OK;
      res = bit_res;
    end
  end

  always_comb begin
    zero = s1_res == '0;
    unique case (s1_cls)
      C_ILL:   status = 4'b1100;
      C_OVF:   status = 4'b1001;
      C_IDX:   status = 4'b1010;
      default: status = zero ? 4'b0100 : 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
    end else if (bus.i_acc_clr) begin
      acc <= '0;
    end else if (accept && acc_op && cls == C_OK) begin
      acc <= res;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_cls   <= C_OK;
    end else if (bus.o_ready) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_res <= res;
        s1_cls <= cls;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid      <= 1'b0;
      bus.cache_result <= '0;
      bus.cache_status <= '0;
    end else if (s2_load) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.cache_result <= K'($signed(s1_res));
        bus.cache_status <= status;
      end
    end
  end
endmodule
